// File: rtl/wait_state_memory.sv
// Dual-port 32-bit word memory with a fixed number of wait states per port (A = instruction,
// B = data). Define WAIT_STATE_MEMORY_BUS_ERROR_EN to flag out-of-range addresses with error.
module wait_state_memory #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned MEM_WORDS  = 4096,
  parameter int unsigned A_WAIT     = 0,
  parameter int unsigned B_WAIT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  // Port A (instruction)
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [31:0]           a_din,
  input  logic [3:0]            a_wr,
  input  logic                  a_enable,
  output logic [31:0]           a_dout,
  output logic                  a_ready,
  output logic                  a_error,
  // Port B (data)
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [31:0]           b_din,
  input  logic [3:0]            b_wr,
  input  logic                  b_enable,
  output logic [31:0]           b_dout,
  output logic                  b_ready,
  output logic                  b_error
);

  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] MemWordsL = (ADDR_WIDTH + 1)'(MEM_WORDS);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StDone
  } state_e;

  logic [ADDR_WIDTH-1:0] addr_in   [2];
  logic [31:0]           din_in    [2];
  logic [3:0]            wr_in     [2];
  logic [1:0]            en_in;

  logic [IdxW-1:0]       mem_idx   [2];
  logic [31:0]           mem_wdata [2];
  logic [3:0]            mem_we    [2];
  logic [31:0]           dout_arr  [2];
  logic [1:0]            ready_arr;
  logic [1:0]            error_arr;

  logic [31:0]           mem [MEM_WORDS];

  assign addr_in[0] = a_addr;
  assign addr_in[1] = b_addr;
  assign din_in[0]  = a_din;
  assign din_in[1]  = b_din;
  assign wr_in[0]   = a_wr;
  assign wr_in[1]   = b_wr;
  assign en_in      = {b_enable, a_enable};

  for (genvar p = 0; p < 2; p++) begin : g_port
    localparam logic [3:0] WaitCnt = 4'((p == 0) ? A_WAIT : B_WAIT);

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           din_q;
    logic [3:0]            wr_q;
    logic                  ready_q;
    logic                  error_q;
    logic [31:0]           dout_q;

    logic [ADDR_WIDTH-1:0] addr_eff;
    logic [31:0]           din_eff;
    logic [3:0]            wr_eff;
    logic                  fire;
    logic                  oor;

    // A zero-wait access completes on its accepting edge, before the capture registers load.
    assign addr_eff = (state_q == StIdle) ? addr_in[p] : addr_q;
    assign din_eff  = (state_q == StIdle) ? din_in[p] : din_q;
    assign wr_eff   = (state_q == StIdle) ? wr_in[p] : wr_q;

    assign fire = ~rst & en_in[p] &
                  (((state_q == StIdle) & (WaitCnt == 4'd0)) |
                   ((state_q == StWait) & (cnt_q == 4'd1)));

`ifdef WAIT_STATE_MEMORY_BUS_ERROR_EN
    assign oor        = ({1'b0, addr_eff} >= MemWordsL);
    assign mem_idx[p] = IdxW'(addr_eff);
`else
    assign oor        = 1'b0;
    assign mem_idx[p] = IdxW'({1'b0, addr_eff} % MemWordsL);
`endif

    assign mem_we[p]    = (fire && !oor) ? wr_eff : 4'b0000;
    assign mem_wdata[p] = din_eff;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        addr_q  <= '0;
        din_q   <= '0;
        wr_q    <= '0;
        ready_q <= 1'b0;
        error_q <= 1'b0;
        dout_q  <= '0;
      end else begin
        ready_q <= 1'b0;
        error_q <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (en_in[p]) begin
              addr_q <= addr_in[p];
              din_q  <= din_in[p];
              wr_q   <= wr_in[p];
              if (WaitCnt == 4'd0) begin
                state_q <= StDone;
              end else begin
                state_q <= StWait;
                cnt_q   <= WaitCnt;
              end
            end
          end
          StWait: begin
            if (!en_in[p]) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_q == 4'd1) begin
              state_q <= StDone;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase

        if (fire) begin
          if (oor) begin
            error_q <= 1'b1;
          end else begin
            ready_q <= 1'b1;
            if (wr_eff == 4'b0000) dout_q <= mem[mem_idx[p]];
          end
        end
      end
    end

    assign dout_arr[p]  = dout_q;
    assign ready_arr[p] = ready_q;
    assign error_arr[p] = error_q;
  end

  // Port B is applied last, so it owns any byte lane both ports write on the same edge.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      for (int l = 0; l < 4; l++) begin
        if (mem_we[p][l]) mem[mem_idx[p]][8*l +: 8] <= mem_wdata[p][8*l +: 8];
      end
    end
  end

  assign a_dout  = dout_arr[0];
  assign a_ready = ready_arr[0];
  assign a_error = error_arr[0];
  assign b_dout  = dout_arr[1];
  assign b_ready = ready_arr[1];
  assign b_error = error_arr[1];

endmodule

// File: tb/tb_wait_state_memory.sv
// Bench for wait_state_memory: directed cases plus random traffic checked every cycle against a
// transaction-level model (completion times, byte-lane merge, out-of-range handling).
module tb_wait_state_memory;

  localparam int unsigned AW    = 12;
  localparam int unsigned MW    = 1024;
  localparam int unsigned AWAIT = 0;
  localparam int unsigned BWAIT = 3;
`ifdef WAIT_STATE_MEMORY_BUS_ERROR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic [AW-1:0] a_addr   = '0;
  logic [31:0]   a_din    = '0;
  logic [3:0]    a_wr     = '0;
  logic          a_enable = 1'b0;
  logic [31:0]   a_dout;
  logic          a_ready;
  logic          a_error;
  logic [AW-1:0] b_addr   = '0;
  logic [31:0]   b_din    = '0;
  logic [3:0]    b_wr     = '0;
  logic          b_enable = 1'b0;
  logic [31:0]   b_dout;
  logic          b_ready;
  logic          b_error;

  int unsigned checks = 0;
  int unsigned errors = 0;

  wait_state_memory #(
    .ADDR_WIDTH(AW),
    .MEM_WORDS (MW),
    .A_WAIT    (AWAIT),
    .B_WAIT    (BWAIT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .a_addr  (a_addr),
    .a_din   (a_din),
    .a_wr    (a_wr),
    .a_enable(a_enable),
    .a_dout  (a_dout),
    .a_ready (a_ready),
    .a_error (a_error),
    .b_addr  (b_addr),
    .b_din   (b_din),
    .b_wr    (b_wr),
    .b_enable(b_enable),
    .b_dout  (b_dout),
    .b_ready (b_ready),
    .b_error (b_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted request completes WAIT edges later if enable stays high;
  // the edge after a completion is dead time.
  int unsigned   cyc = 0;
  bit            m_pend    [2];
  bit            m_cool    [2];
  int unsigned   m_done_at [2];
  logic [AW-1:0] m_addr    [2];
  logic [31:0]   m_din     [2];
  logic [3:0]    m_wr      [2];
  logic [31:0]   e_dout    [2];
  bit            e_ready   [2];
  bit            e_error   [2];
  logic [31:0]   m_mem     [MW];

  task automatic model_step();
    bit            fire [2];
    bit            oor  [2];
    int unsigned   idx  [2];
    int unsigned   wt;
    logic          en;
    logic [AW-1:0] ad;
    logic [31:0]   dn;
    logic [3:0]    wr;
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        m_pend[p]  = 1'b0;
        m_cool[p]  = 1'b0;
        e_ready[p] = 1'b0;
        e_error[p] = 1'b0;
        e_dout[p]  = '0;
      end
      return;
    end
    cyc++;
    for (int p = 0; p < 2; p++) begin
      en = (p == 0) ? a_enable : b_enable;
      ad = (p == 0) ? a_addr : b_addr;
      dn = (p == 0) ? a_din : b_din;
      wr = (p == 0) ? a_wr : b_wr;
      wt = (p == 0) ? AWAIT : BWAIT;
      fire[p]    = 1'b0;
      oor[p]     = 1'b0;
      idx[p]     = 0;
      e_ready[p] = 1'b0;
      e_error[p] = 1'b0;
      if (m_cool[p]) begin
        m_cool[p] = 1'b0;
      end else if (m_pend[p]) begin
        if (!en) m_pend[p] = 1'b0;
        else if (cyc == m_done_at[p]) begin
          m_pend[p] = 1'b0;
          fire[p]   = 1'b1;
        end
      end else if (en) begin
        m_addr[p] = ad;
        m_din[p]  = dn;
        m_wr[p]   = wr;
        if (wt == 0) fire[p] = 1'b1;
        else begin
          m_pend[p]    = 1'b1;
          m_done_at[p] = cyc + wt;
        end
      end
    end
    // All reads see the memory as it was before this edge's writes.
    for (int p = 0; p < 2; p++) begin
      if (fire[p]) begin
        oor[p]    = (32'(m_addr[p]) >= MW);
        idx[p]    = 32'(m_addr[p]) % MW;
        m_cool[p] = 1'b1;
        if (oor[p] && ErrEn) e_error[p] = 1'b1;
        else begin
          e_ready[p] = 1'b1;
          if (m_wr[p] == 4'b0000) e_dout[p] = m_mem[idx[p]];
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (fire[p] && !(oor[p] && ErrEn)) begin
        for (int l = 0; l < 4; l++) begin
          if (m_wr[p][l]) m_mem[idx[p]][8*l +: 8] = m_din[p][8*l +: 8];
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      #1;
      check1("a_ready", a_ready, e_ready[0]);
      check1("a_error", a_error, e_error[0]);
      check("a_dout", a_dout, e_dout[0]);
      check1("b_ready", b_ready, e_ready[1]);
      check1("b_error", b_error, e_error[1]);
      check("b_dout", b_dout, e_dout[1]);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [31:0] init_val(input int unsigned i);
    case (i)
      2:       return 32'h22222222;
      5:       return 32'hDEADBEEF;
      6:       return 32'h66666666;
      7:       return 32'hAAAAAAAA;
      9:       return 32'h99887766;
      default: return 32'h01010101 * i;
    endcase
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    int unsigned r = $urandom_range(0, 7);
    if ($urandom_range(0, 7) == 0) r += MW;
    return AW'(r);
  endfunction

  // Called on a negedge; returns on a negedge with port A idle.
  task automatic a_write(input logic [AW-1:0] ad, input logic [31:0] d);
    a_addr = ad; a_din = d; a_wr = 4'hF; a_enable = 1'b1;
    @(posedge clk); #1;
    check1("a_write ready", a_ready, 1'b1);
    @(negedge clk); a_enable = 1'b0; a_wr = 4'h0;
    @(negedge clk);
  endtask

  task automatic a_read(input logic [AW-1:0] ad, input logic [31:0] exp, input string name);
    a_addr = ad; a_wr = 4'h0; a_enable = 1'b1;
    @(posedge clk); #1;
    check1({name, " ready"}, a_ready, 1'b1);
    check({name, " data"}, a_dout, exp);
    @(negedge clk); a_enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic b_access(input logic [AW-1:0] ad, input logic [3:0] wr, input logic [31:0] d,
                          output logic rdy, output logic err, output logic [31:0] q);
    b_addr = ad; b_wr = wr; b_din = d; b_enable = 1'b1;
    repeat (BWAIT + 1) @(posedge clk);
    #1;
    rdy = b_ready; err = b_error; q = b_dout;
    @(negedge clk); b_enable = 1'b0; b_wr = 4'h0;
    @(negedge clk);
  endtask

  initial begin
    logic        r;
    logic        e;
    logic [31:0] q;

    repeat (3) @(negedge clk);
    check1("reset a_ready", a_ready, 1'b0);
    check1("reset b_ready", b_ready, 1'b0);
    check1("reset b_error", b_error, 1'b0);
    check("reset a_dout", a_dout, 32'h0);
    check("reset b_dout", b_dout, 32'h0);

    // Release reset and issue the first preload write on the very next edge.
    rst = 1'b0;
    for (int i = 0; i < 32; i++) a_write(AW'(i), init_val(i));

    a_read(12'd5, 32'hDEADBEEF, "zero-wait read");

    // Port B lane write with three wait states.
    b_addr = 12'd7; b_din = 32'h11223344; b_wr = 4'b0101; b_enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check1("b_ready before latency", b_ready, 1'b0);
    end
    @(posedge clk); #1;
    check1("b_write latency", b_ready, 1'b1);
    @(negedge clk); b_enable = 1'b0; b_wr = 4'h0;
    @(posedge clk); #1;
    check1("b_ready single pulse", b_ready, 1'b0);
    @(negedge clk);
    a_read(12'd7, 32'hAA22AA44, "word7 lanes");
    check("model word7", m_mem[7], 32'hAA22AA44);

    // Both ports write word 9 on the same edge.
    b_addr = 12'd9; b_din = 32'h00BBBB00; b_wr = 4'b0110; b_enable = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_addr = 12'd9; a_din = 32'h0000CCCC; a_wr = 4'b0011; a_enable = 1'b1;
    @(posedge clk); #1;
    check1("collide a_ready", a_ready, 1'b1);
    check1("collide b_ready", b_ready, 1'b1);
    @(negedge clk); a_enable = 1'b0; b_enable = 1'b0; a_wr = 4'h0; b_wr = 4'h0;
    @(negedge clk);
    a_read(12'd9, 32'h99BBBBCC, "word9 merge");
    check("model word9", m_mem[9], 32'h99BBBBCC);

    // Abort: enable dropped after two cycles of a port B write.
    b_addr = 12'd2; b_din = 32'hFFFFFFFF; b_wr = 4'hF; b_enable = 1'b1;
    @(negedge clk);
    @(negedge clk); b_enable = 1'b0; b_wr = 4'h0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check1("abort no b_ready", b_ready, 1'b0);
    end
    @(negedge clk);
    a_read(12'd2, 32'h22222222, "word2 after abort");

    // Out-of-range access.
    b_access(12'd4, 4'h0, 32'h0, r, e, q);
    check1("b read4 ready", r, 1'b1);
    check("b read4 data", q, 32'h04040404);
    b_access(12'd1030, 4'h0, 32'h0, r, e, q);
`ifdef WAIT_STATE_MEMORY_BUS_ERROR_EN
    check1("oor ready", r, 1'b0);
    check1("oor error", e, 1'b1);
    check("oor dout held", q, 32'h04040404);
`else
    check1("wrap ready", r, 1'b1);
    check1("wrap error", e, 1'b0);
    check("wrap data", q, 32'h66666666);
`endif

    // Reset in the middle of a port B write.
    b_addr = 12'd3; b_din = 32'hFFFFFFFF; b_wr = 4'hF; b_enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1; b_enable = 1'b0; b_wr = 4'h0;
    #1;
    check1("async rst b_ready", b_ready, 1'b0);
    check1("async rst b_error", b_error, 1'b0);
    check("async rst b_dout", b_dout, 32'h0);
    check("async rst a_dout", a_dout, 32'h0);
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    b_access(12'd3, 4'h0, 32'h0, r, e, q);
    check1("post-reset ready", r, 1'b1);
    check("post-reset word3", q, 32'h03030303);

    // Random traffic on both ports.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      a_enable = ($urandom_range(0, 99) < 85);
      a_addr   = rand_addr();
      a_din    = $urandom;
      a_wr     = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      b_enable = ($urandom_range(0, 99) < 85);
      b_addr   = rand_addr();
      b_din    = $urandom;
      b_wr     = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    a_enable = 1'b0; b_enable = 1'b0; a_wr = 4'h0; b_wr = 4'h0;
    repeat (8) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wait_state_memory.md
WAIT_STATE_MEMORY -- requirements
Module: wait_state_memory

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, word-address width of both ports.
REQ-002 SHALL have parameter MEM_WORDS, default 4096, number of implemented 32-bit words (1 .. 2^ADDR_WIDTH).
REQ-003 SHALL have parameter A_WAIT, default 0, wait states on port A (0..15).
REQ-004 SHALL have parameter B_WAIT, default 1, wait states on port B (0..15).
REQ-005 SHALL have ports: clk  in  1  single clock; rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have port A (instruction): a_addr in ADDR_WIDTH word address; a_din in 32 write data; a_wr in 4 byte-lane write enables; a_enable in 1 request; a_dout out 32 read data; a_ready out 1 completion; a_error out 1 bus error.
REQ-007 SHALL have port B (data) with identically named b_* ports of the same widths and meanings.

Function
REQ-008 Each port SHALL run an independent FSM: IDLE, WAIT, DONE.
REQ-009 IDLE with enable=1 at a clock edge SHALL capture addr/din/wr; go to WAIT with counter=<X>_WAIT, or to DONE directly when <X>_WAIT=0.
REQ-010 WAIT SHALL decrement counter each cycle; at counter=1 go to DONE.
REQ-011 DONE SHALL assert ready (or error) for exactly one cycle, then return to IDLE; latency enable-sampled -> ready = <X>_WAIT+1 cycles.
REQ-012 A request still asserted in the cycle after ready SHALL be treated as a new request (back-to-back throughput one access per <X>_WAIT+2 cycles).
REQ-013 enable deasserted in WAIT SHALL abort: return to IDLE, no ready, no error, no memory write.
REQ-014 Memory access SHALL occur on the DONE transition edge only, using captured values.
REQ-015 wr=4'b0000 SHALL be a read: dout loads the word at that edge; ready asserts concurrently with valid dout.
REQ-016 wr!=0 SHALL write only lanes whose wr bit is 1 (bit0 = bits 7:0); dout unchanged.
REQ-017 dout SHALL hold its last read value until the next read completes.
REQ-018 Same-edge write by both ports to one word: non-overlapping lanes both apply; overlapping lanes take port B data.
REQ-019 Same-edge read on one port and write on the other to one word: read returns pre-write data.
REQ-020 Address >= MEM_WORDS handling SHALL follow REQ-026/REQ-027.

Reset
REQ-021 rst=1 SHALL immediately force both FSMs to IDLE, counters 0, ready=0, error=0, dout=32'h0.
REQ-022 Reset mid-operation SHALL discard the in-flight request with no write; memory contents SHALL NOT be cleared.
REQ-023 First request SHALL be accepted on the first clk edge after rst deasserts.

Configuration
REQ-024 Macro WAIT_STATE_MEMORY_BUS_ERROR_EN SHALL select out-of-range behaviour.
REQ-025 Address out of range SHALL be decided on captured address (addr >= MEM_WORDS).
REQ-026 Defined: out-of-range access SHALL pulse error (not ready) in DONE, no write, dout unchanged.
REQ-027 Undefined: error SHALL be tied 0; address SHALL wrap modulo MEM_WORDS; access completes with ready.

Verification
REQ-028 A_WAIT=0: a_enable=1, a_wr=0, a_addr=5 holding 32'hDEADBEEF -> a_ready high 1 cycle later, a_dout=32'hDEADBEEF.
REQ-029 B_WAIT=3: b_wr=4'b0101, b_din=32'h11223344 to word 7 initially 32'hAAAAAAAA -> b_ready 4 cycles later; readback 32'hAA22AA44.
REQ-030 Same edge, both ports write word 9: a_wr=4'b0011 din 32'h0000CCCC, b_wr=4'b0110 din 32'h00BBBB00 -> word 9 = xx_BB_BB_CC (byte3 unchanged).
REQ-031 B_WAIT=3: b_enable dropped after 2 cycles of a write to word 2 -> no b_ready; word 2 unchanged.
REQ-032 MEM_WORDS=1024, macro defined: read address 1030 -> b_error one cycle, b_ready=0; macro undefined -> b_ready, data of word 6.
REQ-033 rst pulsed during B WAIT -> b_ready/b_error/b_dout=0 asynchronously; prior memory contents intact on next read.
